// File: rtl/sincos_arbiter.sv
// sincos_arbiter
//   Shares one sin_cos lookup among N_REQ requesters. A round-robin arbiter
//   picks at most one request per cycle. It registers the winner's phase onto
//   sc_phase and tracks the owner through a tag pipeline that is LAT+1 stages
//   deep. When the sin_cos results arrive, they are registered and broadcast.
//   A one-hot rsp_valid pulse marks the owner of each response.
// Ports
//   clk        system clock, rising edge
//   resetN     synchronous active-low reset
//   req        per-requester level request
//   phase_in   packed phases, requester i at [i*PHASE_W +: PHASE_W]
//   grant      combinational one-hot (or zero) accept for this cycle
//   sc_phase   registered phase to the shared sin_cos instance
//   sc_sin/cos signed results returned by the sin_cos instance
//   rsp_valid  one-hot one-cycle response owner marker
//   rsp_sin/cos registered results, broadcast to all requesters
//   busy       high while an accepted lookup has not yet responded
module sincos_arbiter #(
  parameter int N_REQ   = 4,
  parameter int PHASE_W = 10,
  parameter int LAT     = 1
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*PHASE_W-1:0]   phase_in,
  output logic [N_REQ-1:0]           grant,
  output logic [PHASE_W-1:0]         sc_phase,
  input  logic signed [17:0]         sc_sin,
  input  logic signed [17:0]         sc_cos,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic signed [17:0]         rsp_sin,
  output logic signed [17:0]         rsp_cos,
  output logic                       busy
);

  localparam int ID_W = $clog2(N_REQ);

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [PHASE_W-1:0] sc_phase_q, sc_phase_d;
  logic [LAT:0]       tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]    tag_id_q [LAT+1];
  logic [ID_W-1:0]    tag_id_d [LAT+1];
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic signed [17:0] rsp_sin_q, rsp_sin_d;
  logic signed [17:0] rsp_cos_q, rsp_cos_d;
  logic               busy_q, busy_d;

  logic               win_vld_s;
  logic [ID_W-1:0]    win_id_s;
  logic [ID_W-1:0]    cand_s;
  logic [N_REQ-1:0]   grant_s;

  // Round-robin search from ptr upward with wrap; the first requester found wins.
  always_comb begin
    win_vld_s = 1'b0;
    win_id_s  = '0;
    cand_s    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_s    = ID_W'((32'(ptr_q) + 32'(k)) % 32'(N_REQ));
      // Only the first hit updates the winner; later hits leave it untouched.
      win_id_s  = (!win_vld_s && req[cand_s]) ? cand_s : win_id_s;
      win_vld_s = win_vld_s | req[cand_s];
    end
    grant_s = '0;
    if (win_vld_s && resetN) begin
      grant_s[win_id_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Next-state: pointer/phase capture on a grant, tag shift, response load.
  always_comb begin
    ptr_d      = ptr_q;
    sc_phase_d = sc_phase_q;
    if (win_vld_s) begin
      ptr_d = (win_id_s == ID_W'(N_REQ - 1)) ? '0 : win_id_s + ID_W'(1);
      for (int i = 0; i < N_REQ; i++) begin
        sc_phase_d = (win_id_s == ID_W'(i)) ? phase_in[i*PHASE_W +: PHASE_W] : sc_phase_d;
      end
    end else begin
      ptr_d      = ptr_q;
      sc_phase_d = sc_phase_q;
    end

    // A cycle without a grant shifts in a bubble (valid=0).
    tag_vld_d   = {tag_vld_q[LAT-1:0], win_vld_s};
    tag_id_d[0] = win_id_s;
    for (int s = 1; s <= LAT; s++) begin
      tag_id_d[s] = tag_id_q[s-1];
    end

    // The last tag stage lines up with the sin_cos results for that lookup.
    rsp_valid_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid_d[i] = tag_vld_q[LAT] && (tag_id_q[LAT] == ID_W'(i));
    end
    if (tag_vld_q[LAT]) begin
      rsp_sin_d = sc_sin;
      rsp_cos_d = sc_cos;
    end else begin
      rsp_sin_d = rsp_sin_q;
      rsp_cos_d = rsp_cos_q;
    end

    // busy reflects the tag valids as they will be after this edge.
    busy_d = |tag_vld_d;
  end

  // State registers with synchronous reset; in-flight tags are discarded.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      ptr_q       <= '0;
      sc_phase_q  <= '0;
      tag_vld_q   <= '0;
      for (int s = 0; s <= LAT; s++) begin
        tag_id_q[s] <= '0;
      end
      rsp_valid_q <= '0;
      rsp_sin_q   <= '0;
      rsp_cos_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      sc_phase_q  <= sc_phase_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sin_q   <= rsp_sin_d;
      rsp_cos_q   <= rsp_cos_d;
      busy_q      <= busy_d;
    end
  end

  assign grant     = grant_s;
  assign sc_phase  = sc_phase_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sin   = rsp_sin_q;
  assign rsp_cos   = rsp_cos_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sincos_arbiter.sv
// tb_sincos_arbiter
//   Directed bench for sincos_arbiter with default parameters (4 requesters,
//   10-bit phase, LAT=1). A behavioural sin_cos stand-in returns a known
//   function of sc_phase one cycle later. Stimulus pushes expected responses
//   into a queue, and a negedge monitor pops and compares them.
module tb_sincos_arbiter;

  logic               clk = 1'b0;
  logic               resetN;
  logic [3:0]         req;
  logic [39:0]        phase_in;
  logic [3:0]         grant;
  logic [9:0]         sc_phase;
  logic signed [17:0] sc_sin, sc_cos;
  logic [3:0]         rsp_valid;
  logic signed [17:0] rsp_sin, rsp_cos;
  logic               busy;

  sincos_arbiter #(.N_REQ(4), .PHASE_W(10), .LAT(1)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .req       (req),
    .phase_in  (phase_in),
    .grant     (grant),
    .sc_phase  (sc_phase),
    .sc_sin    (sc_sin),
    .sc_cos    (sc_cos),
    .rsp_valid (rsp_valid),
    .rsp_sin   (rsp_sin),
    .rsp_cos   (rsp_cos),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in lookup: phase 3FF maps to the most negative test value.
  function automatic logic signed [17:0] f_sin(input logic [9:0] p);
    return (p == 10'h3FF) ? -18'sd65536 : $signed({8'h00, p});
  endfunction
  function automatic logic signed [17:0] f_cos(input logic [9:0] p);
    return 18'sd0 - $signed({8'h00, p});
  endfunction

  always @(posedge clk) begin
    sc_sin <= f_sin(sc_phase);
    sc_cos <= f_cos(sc_phase);
  end

  typedef struct {
    logic [3:0]         oh;
    logic signed [17:0] s;
    logic signed [17:0] c;
    int                 due;
  } exp_t;

  exp_t               q[$];
  int                 n_chk  = 0;
  int                 n_pass = 0;
  logic [9:0]         ph [4];
  logic [9:0]         sc_exp;
  logic signed [17:0] last_s = 18'sd0;
  logic signed [17:0] last_c = 18'sd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Monitor: every rsp_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rsp_valid !== 4'h0) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_rsp: got rsp_valid %b expected none (cycle %0d)", rsp_valid, cyc);
      end else begin
        e = q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(e.oh));
        chk("rsp_sin", 32'(rsp_sin), 32'(e.s));
        chk("rsp_cos", 32'(rsp_cos), 32'(e.c));
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
        last_s = e.s;
        last_c = e.c;
      end
    end
  end

  function automatic logic busy_model();
    foreach (q[i]) if (q[i].due > cyc) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle: drive req, check grant, sc_phase and busy, and record the expected response.
  task automatic step(input logic [3:0] r, input logic [3:0] eg);
    int   id;
    exp_t e;
    @(negedge clk);
    req      = r;
    phase_in = {ph[3], ph[2], ph[1], ph[0]};
    #1;
    chk("grant", 32'(grant), 32'(eg));
    chk("sc_phase", 32'(sc_phase), 32'(sc_exp));
    chk("busy", 32'(busy), 32'(busy_model()));
    if (eg != 4'h0) begin
      id = 0;
      for (int i = 0; i < 4; i++) if (eg[i]) id = i;
      e.oh  = eg;
      e.s   = f_sin(ph[id]);
      e.c   = f_cos(ph[id]);
      e.due = cyc + 3;
      q.push_back(e);
      sc_exp = ph[id];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'h0, 4'h0);
  endtask

  initial begin
    resetN   = 1'b0;
    req      = 4'hF;
    phase_in = 40'h0;
    sc_exp   = 10'h000;
    for (int i = 0; i < 4; i++) ph[i] = 10'h000;

    // Reset: grant is suppressed even with all requests high.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("grant_in_reset", 32'(grant), 32'h0);
    end
    @(negedge clk);
    resetN = 1'b1;
    req    = 4'h0;
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sc_phase", 32'(sc_phase), 32'h0);
    chk("rst_rsp_sin", 32'(rsp_sin), 32'h0);
    chk("rst_rsp_cos", 32'(rsp_cos), 32'h0);

    // All requesters held: grants 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      ph[k % 4] = 10'h020 + 10'(k);
      step(4'hF, 4'(1 << (k % 4)));
    end

    // Idle: no grants, outputs hold the last response (phase 027).
    idle(10);
    chk("idle_rsp_sin", 32'(rsp_sin), 32'(18'sd39));
    chk("idle_rsp_cos", 32'(rsp_cos), 32'(-18'sd39));
    chk("idle_sc_phase", 32'(sc_phase), 32'(10'h027));

    // Single request from requester 2.
    ph[2] = 10'h100;
    step(4'b0100, 4'b0100);
    idle(4);

    // Two requesters alternate; requester 3 joins mid-stream (ptr was 3).
    ph[0] = 10'h0A0; ph[1] = 10'h0B0; ph[3] = 10'h0D0;
    step(4'b0011, 4'b0001);
    step(4'b0011, 4'b0010);
    step(4'b0011, 4'b0001);
    step(4'b0011, 4'b0010);
    step(4'b1011, 4'b1000);
    step(4'b1011, 4'b0001);
    step(4'b1011, 4'b0010);
    step(4'b1011, 4'b1000);
    idle(4);

    // Wrap from ptr=3 with req 1001; negative result passes bit-exact.
    ph[2] = 10'h0C0;
    step(4'b0100, 4'b0100);
    ph[3] = 10'h3FF; ph[0] = 10'h001;
    step(4'b1001, 4'b1000);
    step(4'b1001, 4'b0001);
    idle(5);
    chk("neg_last_sin", 32'(last_s), 32'(18'sd1));

    // Reset mid-flight: the lookup granted just before reset is discarded.
    @(negedge clk);
    ph[0]    = 10'h055;
    req      = 4'b0001;
    phase_in = {ph[3], ph[2], ph[1], ph[0]};
    #1;
    chk("pre_rst_grant", 32'(grant), 32'h1);
    @(negedge clk);
    resetN = 1'b0;
    #1;
    chk("rst_grant_gated", 32'(grant), 32'h0);
    chk("rst_busy_inflight", 32'(busy), 32'h1);
    @(negedge clk);
    resetN = 1'b1;
    req    = 4'h0;
    sc_exp = 10'h000;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_rsp_sin", 32'(rsp_sin), 32'h0);
    chk("mid_rst_rsp_cos", 32'(rsp_cos), 32'h0);
    idle(5);

    // Arbitration restarts from ptr=0.
    ph[0] = 10'h0E0;
    step(4'hF, 4'b0001);
    idle(2);

    // Drain: all outstanding responses must appear within a bounded wait.
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", 32'(q.size()), 32'h0);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sincos_arbiter.md
SINCOS_ARBITER -- requirements
Module: sincos_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one sin_cos lookup (2..8).
REQ-002 Parameter PHASE_W, default 10, phase width in bits.
REQ-003 Parameter LAT, default 1, clock cycles from the sin_cos phase input to valid sin_val/cos_val (1..4).
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 resetN  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-006 req  input  N_REQ  per-requester lookup request, level.
REQ-007 phase_in  input  N_REQ*PHASE_W  packed phases; requester i occupies bits [i*PHASE_W +: PHASE_W].
REQ-008 grant  output  N_REQ  one-hot or zero; combinational; indicates the request accepted this cycle.
REQ-009 sc_phase  output  PHASE_W  registered phase driven to the shared sin_cos instance.
REQ-010 sc_sin, sc_cos  input  18 each  signed results returned from the shared sin_cos instance.
REQ-011 rsp_valid  output  N_REQ  one-hot, one-cycle pulse; marks the response owner.
REQ-012 rsp_sin, rsp_cos  output  18 each  signed registered results, broadcast to all requesters.
REQ-013 busy  output  1  high while any accepted lookup has not yet produced rsp_valid.

Function
REQ-014 Arbitration: round-robin; search starts at pointer ptr and proceeds upward, wrapping N_REQ-1 to 0; the first i with req[i]=1 wins.
REQ-015 At most one grant per cycle; grant=0 when req=0 or resetN=0.
REQ-016 On an edge with grant[i]=1: sc_phase <= phase_in[i]; ptr <= (i+1) mod N_REQ; owner id i enters the tag pipeline.
REQ-017 On an edge with no grant: ptr and sc_phase hold; a bubble (invalid tag) enters the tag pipeline.
REQ-018 Requester contract: hold req and phase_in stable until grant; req still high on the cycle after a grant is a new request.
REQ-019 Latency: grant in cycle T -> sc_phase updated from cycle T+1 -> sc_sin/sc_cos sampled at end of cycle T+1+LAT -> rsp_valid[i] high in cycle T+2+LAT only.
REQ-020 Tag pipeline: LAT+1 stages of {valid, id[$clog2(N_REQ)-1:0]}; fully pipelined, one accepted lookup per cycle, never stalls.
REQ-021 rsp_sin/rsp_cos load only on the edge that sets a rsp_valid bit; they hold the value otherwise.
REQ-022 busy = OR of all tag-pipeline valid bits, registered with the pipeline; busy stays low when only bubbles are in flight.
REQ-023 Fairness: with all requests held, grants follow 0,1,...,N_REQ-1,0,...; worst-case wait for a continuously asserted request is N_REQ-1 cycles.
REQ-024 Responses return in grant order; back-to-back grants to the same requester yield rsp_valid on consecutive cycles.
REQ-025 Values pass through unchanged: no sign extension, scaling or saturation of sc_sin/sc_cos.

Reset
REQ-026 While resetN=0 at a rising edge: ptr=0, sc_phase=0, all tag valids=0, rsp_valid=0, rsp_sin=0, rsp_cos=0, busy=0.
REQ-027 Lookups in flight when reset is asserted are discarded; no rsp_valid is produced for them after reset is released.
REQ-028 In the first cycle after resetN rises, arbitration starts from ptr=0.

Verification
REQ-029 Single request, LAT=1: req=0b0100, phase_in[2]=10'h100 in cycle 5 -> grant=0b0100 in cycle 5; sc_phase=10'h100 from cycle 6; sc_sin/sc_cos returned in cycle 7; rsp_valid=0b0100 with matching values in cycle 8.
REQ-030 All requesters held for 8 cycles after reset -> grants 0,1,2,3,0,1,2,3; rsp_valid follows the same order 3 cycles later, one pulse per cycle.
REQ-031 Round-robin fairness: req=0b0011 held -> grants alternate 0,1,0,1; add req[3] mid-stream -> req[3] is granted within 3 cycles.
REQ-032 Reset mid-flight: grant issued in cycle T, resetN=0 in cycle T+1 -> no rsp_valid in cycles T+1..T+5; busy=0 and rsp_sin=rsp_cos=0 after the reset edge.
REQ-033 Idle: req=0 for 10 cycles -> grant=0, rsp_valid=0, busy=0, sc_phase and rsp_sin/rsp_cos unchanged.
REQ-034 Wrap-around and sign: ptr=3 with req=0b1001 -> grant to 3, then to 0; negative sc_sin=-18'sd65536 appears bit-exact on rsp_sin.
